register_file_wb_sink: RTL and testbench

//  Architectural integer register file (x0..x31) of the 5-stage RV32I pipeline.
//  It is the receiving end of the write-back interface: it consumes the

---
 rtl/register_file_wb_sink.sv | 87 ++++++++
 tb/tb_register_file_wb_sink.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/register_file_wb_sink.sv
// Architectural integer register file (x0..x31) for the 5-stage RV32I pipeline.
// Write-back stage writes one entry per cycle; decode stage reads two ports
// combinationally, with optional same-cycle write-to-read bypass.

// One combinational read port: x0 and reset force zero, bypass wins over array.
module register_file_wb_sink_rd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic                                  rst,
  input  logic                                  wr_en,
  input  logic [ADDR_W-1:0]                     wr_idx,
  input  logic [DATA_W-1:0]                     wr_data,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]    mem,
  input  logic [ADDR_W-1:0]                     addr,
  output logic [DATA_W-1:0]                     rd
);
  // Select zero, forwarded write data, or stored contents.
  always_comb begin
    rd = mem[addr];
    if (!rst || addr == '0)
      rd = '0;
    else if (BYPASS && wr_en && wr_idx == addr)
      rd = wr_data;
  end
endmodule

module register_file_wb_sink #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW,
  input  logic [ADDR_W-1:0] WriteRegW,
  input  logic [DATA_W-1:0] WriteDataW,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [15:0]       wr_count
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NUM_RD = 2;

  logic [DEPTH-1:0][DATA_W-1:0]  mem;
  logic [NUM_RD-1:0][ADDR_W-1:0] addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd;
  logic                          wr_en;

  // Writes to x0 are dropped entirely, so entry 0 stays at its reset value.
  assign wr_en = RegWriteW && (WriteRegW != '0);

  assign addr = {A2, A1};
  assign RD1  = rd[0];
  assign RD2  = rd[1];

  // Commit write-back data; count committed writes, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem      <= '0;
      wr_count <= '0;
    end else if (wr_en) begin
      mem[WriteRegW] <= WriteDataW;
      if (wr_count != 16'hFFFF)
        wr_count <= wr_count + 16'd1;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    register_file_wb_sink_rd #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_rd (
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_idx  (WriteRegW),
      .wr_data (WriteDataW),
      .mem     (mem),
      .addr    (addr[p]),
      .rd      (rd[p])
    );
  end
endmodule

// File: tb/tb_register_file_wb_sink.sv
// Scoreboard bench for register_file_wb_sink: stimulus pushes expected read
// data and write count; a negedge monitor pops and compares.
module tb_register_file_wb_sink;
  localparam bit BYP = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteW = 1'b0;
  logic [4:0]  WriteRegW = '0;
  logic [31:0] WriteDataW = '0;
  logic [4:0]  A1 = '0;
  logic [4:0]  A2 = '0;
  logic [31:0] RD1, RD2;
  logic [15:0] wr_count;

  register_file_wb_sink #(.DATA_W(32), .ADDR_W(5), .BYPASS(BYP)) dut (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
    .WriteDataW(WriteDataW), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [15:0] cnt;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] model [32];
  int          model_cnt = 0;

  // Reference: what a read port must show right now, from architectural rules.
  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    if (!rst || a == 5'd0) return 32'h0;
    if (BYP && RegWriteW && WriteRegW != 5'd0 && WriteRegW == a) return WriteDataW;
    return model[a];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model_cnt = 0;
  endfunction

  task automatic push_exp(input string tag);
    exp_t e;
    e.rd1 = ref_rd(A1);
    e.rd2 = ref_rd(A2);
    e.cnt = 16'(model_cnt);
    e.tag = tag;
    sb.push_back(e);
  endtask

  // One cycle: drive inputs just after the edge, optionally check, then commit
  // the model at the next rising edge.
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input bit chk, input string tag);
    RegWriteW = we; WriteRegW = wa; WriteDataW = wd; A1 = a1; A2 = a2;
    if (chk) push_exp(tag);
    @(posedge clk);
    if (rst && we && wa != 5'd0) begin
      model[wa] = wd;
      if (model_cnt < 65535) model_cnt++;
    end
    #1;
  endtask

  // Monitor: pop one expectation per cycle and compare on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk += 3;
      if (RD1 !== e.rd1) begin
        n_fail++;
        $display("FAIL %s RD1 got %h want %h", e.tag, RD1, e.rd1);
      end
      if (RD2 !== e.rd2) begin
        n_fail++;
        $display("FAIL %s RD2 got %h want %h", e.tag, RD2, e.rd2);
      end
      if (wr_count !== e.cnt) begin
        n_fail++;
        $display("FAIL %s wr_count got %h want %h", e.tag, wr_count, e.cnt);
      end
    end
  end

  initial begin
    model_clear();
    @(posedge clk); #1;

    // Reset held with random write-back traffic: everything reads zero.
    for (int i = 0; i < 20; i++)
      step(1'b1, 5'($urandom), $urandom, 5'($urandom), 5'($urandom), 1'b1, "reset_hold");
    rst = 1'b1;
    for (int i = 0; i < 32; i++)
      step(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b1, "post_reset_zero");

    // Basic write then read.
    step(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6, 1'b1, "wr_x5");
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b1, "rd_x5");

    // x0 guard.
    step(1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b1, "x0_write");
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 1'b1, "x0_read");

    // Same-cycle bypass on both ports, then registered value.
    step(1'b1, 5'd10, 32'hCAFE0001, 5'd10, 5'd10, 1'b1, "bypass");
    step(1'b0, 5'd0, 32'h0, 5'd10, 5'd10, 1'b1, "after_bypass");

    // Back-to-back writes to one index: last wins.
    step(1'b1, 5'd7, 32'h11111111, 5'd7, 5'd5, 1'b1, "b2b_1");
    step(1'b1, 5'd7, 32'h22222222, 5'd7, 5'd10, 1'b1, "b2b_2");
    step(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b1, "b2b_rd");

    // Async reset pulse between edges with a write presented.
    step(1'b1, 5'd3, 32'd7, 5'd3, 5'd4, 1'b1, "wr_x3");
    step(1'b1, 5'd4, 32'd9, 5'd3, 5'd4, 1'b1, "wr_x4");
    RegWriteW = 1'b1; WriteRegW = 5'd3; WriteDataW = 32'd5; A1 = 5'd3; A2 = 5'd4;
    #1;
    rst = 1'b0;
    model_clear();
    push_exp("async_reset");
    #6;
    RegWriteW = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 1'b1, "after_pulse");

    // Random traffic.
    for (int i = 0; i < 200; i++)
      step(1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom), 1'b1, "random");

    // Sweep all indices then read back via both ports.
    for (int i = 1; i < 32; i++)
      step(1'b1, 5'(i), 32'h100 + 32'(i), 5'(i), 5'(i - 1), 1'b1, "sweep_wr");
    for (int i = 0; i < 32; i++)
      step(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b1, "sweep_rd");

    // Saturation of the write counter.
    for (int i = 0; i < 70000; i++)
      step(1'b1, 5'(1 + (i % 31)), $urandom, 5'd1, 5'd2, (i % 10000) == 0, "saturate");
    step(1'b0, 5'd0, 32'h0, 5'd1, 5'd31, 1'b1, "saturated");
    step(1'b1, 5'd9, 32'hABCD, 5'd9, 5'd0, 1'b1, "saturated_hold");
    step(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, "saturated_final");

    repeat (2) @(posedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
